decode_stage: RTL and testbench

Pipelined RV32IMF instruction decoder between the fetch stage and issue/execute. It accepts raw 32-bit instruction words with their PC and splits each into register indices, a sign-extended immediate, function fields, a target execution unit and control flags, using the team's instruction-encoding definitions. Illegal encodings are flagged, not dropped. A registered output plus a one-entry skid buffer sustain one instruction per cycle under backpressure with registered ready.

---
 rtl/decode_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Pipelined RV32IMF instruction decoder sitting between fetch and issue.
// Each accepted 32-bit instruction word (with its PC) is decoded
// combinationally into register indices, a sign-extended immediate, raw
// function fields, a target execution unit and control flags. Illegal
// encodings are flagged and passed on, never dropped. An output register
// plus a one-entry skid register sustain one instruction per cycle while
// keeping fetch_ready_o a pure function of the state register.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holding valid high keeps its payload stable
// until the transfer; ready may be asserted or withdrawn freely.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   flush_i             synchronous flush; discards held and incoming words
//   fetch_valid_i/ready_o, instr_i, pc_i           upstream side
//   dec_valid_o/ready_i, pc_o, opcode_o, funct3_o, funct7_o,
//   rd_o, rs1_o, rs2_o, rs3_o, imm_o, unit_o,
//   rd_float_o, rs1_float_o, rs2_float_o,
//   writeback_o, illegal_o                         downstream bundle
// -----------------------------------------------------------------------------
module decode_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rs3_o,
    output logic [31:0] imm_o,
    output logic [2:0]  unit_o,
    output logic        rd_float_o,
    output logic        rs1_float_o,
    output logic        rs2_float_o,
    output logic        writeback_o,
    output logic        illegal_o
);

    // Major opcodes
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_FLOAD   = 7'b0000111;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_FSTORE  = 7'b0100111;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_FMADD   = 7'b1000011;
    localparam logic [6:0] OP_FMSUB   = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB  = 7'b1001011;
    localparam logic [6:0] OP_FNMADD  = 7'b1001111;
    localparam logic [6:0] OP_F_OPS   = 7'b1010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_ECSR    = 7'b1110011;

    // F_OPS funct7 values (single precision)
    localparam logic [6:0] F7_FADD    = 7'b0000000;
    localparam logic [6:0] F7_FSUB    = 7'b0000100;
    localparam logic [6:0] F7_FMUL    = 7'b0001000;
    localparam logic [6:0] F7_FDIV    = 7'b0001100;
    localparam logic [6:0] F7_FSQRT   = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ   = 7'b0010000;
    localparam logic [6:0] F7_FMINMAX = 7'b0010100;
    localparam logic [6:0] F7_FCVTW   = 7'b1100000;
    localparam logic [6:0] F7_FMV_CLS = 7'b1110000;
    localparam logic [6:0] F7_FCMP    = 7'b1010000;
    localparam logic [6:0] F7_FCVTS   = 7'b1101000;
    localparam logic [6:0] F7_FMVWX   = 7'b1111000;

    // Execution unit codes
    localparam logic [2:0] UNIT_ALU   = 3'd0;
    localparam logic [2:0] UNIT_BRU   = 3'd1;
    localparam logic [2:0] UNIT_LSU   = 3'd2;
    localparam logic [2:0] UNIT_MDU   = 3'd3;
    localparam logic [2:0] UNIT_FPU   = 3'd4;
    localparam logic [2:0] UNIT_SYS   = 3'd5;
    localparam logic [2:0] UNIT_FENCE = 3'd6;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [31:0] imm;
        logic [2:0]  unit;
        logic        rd_float;
        logic        rs1_float;
        logic        rs2_float;
        logic        writeback;
        logic        illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;

    // ------------------------------------------------------------------
    // Combinational decode of the word currently presented by fetch
    // ------------------------------------------------------------------
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wb_en;
    logic        uses_rm;

    always_comb begin
        dec     = '0;
        wb_en   = 1'b0;
        uses_rm = 1'b0;

        imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
        imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
        imm_u = {instr_i[31:12], 12'b0};
        imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};

        dec.pc     = pc_i;
        dec.opcode = instr_i[6:0];
        dec.funct3 = instr_i[14:12];
        dec.funct7 = instr_i[31:25];
        dec.rd     = instr_i[11:7];
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
        dec.rs3    = instr_i[31:27];

        // Unknown opcodes fall through to the default arm: unit stays ALU,
        // immediate stays zero, and the word is marked illegal.
        unique case (dec.opcode)
            OP_LUI, OP_AUIPC: begin
                dec.unit = UNIT_ALU;
                dec.imm  = imm_u;
                wb_en    = 1'b1;
            end
            OP_ALU_I: begin
                dec.unit = UNIT_ALU;
                dec.imm  = imm_i;
                wb_en    = 1'b1;
                // Shift-immediate forms reuse imm[11:5] as funct7
                if (dec.funct3 == 3'b001 && dec.funct7 != 7'b0000000)
                    dec.illegal = 1'b1;
                if (dec.funct3 == 3'b101 && dec.funct7 != 7'b0000000 &&
                    dec.funct7 != 7'b0100000)
                    dec.illegal = 1'b1;
            end
            OP_REG: begin
                dec.unit = (dec.funct7 == 7'b0000001) ? UNIT_MDU : UNIT_ALU;
                wb_en    = 1'b1;
                if (dec.funct7 != 7'b0000000 && dec.funct7 != 7'b0100000 &&
                    dec.funct7 != 7'b0000001)
                    dec.illegal = 1'b1;
                if (dec.funct7 == 7'b0100000 && dec.funct3 != 3'b000 &&
                    dec.funct3 != 3'b101)
                    dec.illegal = 1'b1;
            end
            OP_BRANCH: begin
                dec.unit = UNIT_BRU;
                dec.imm  = imm_b;
                if (dec.funct3 == 3'b010 || dec.funct3 == 3'b011)
                    dec.illegal = 1'b1;
            end
            OP_JAL: begin
                dec.unit = UNIT_BRU;
                dec.imm  = imm_j;
                wb_en    = 1'b1;
            end
            OP_JALR: begin
                dec.unit = UNIT_BRU;
                dec.imm  = imm_i;
                wb_en    = 1'b1;
            end
            OP_LOAD: begin
                dec.unit = UNIT_LSU;
                dec.imm  = imm_i;
                wb_en    = 1'b1;
                if (dec.funct3 == 3'b011 || dec.funct3 == 3'b110 ||
                    dec.funct3 == 3'b111)
                    dec.illegal = 1'b1;
            end
            OP_STORE: begin
                dec.unit = UNIT_LSU;
                dec.imm  = imm_s;
                if (dec.funct3 > 3'b010)
                    dec.illegal = 1'b1;
            end
            OP_FLOAD: begin
                dec.unit     = UNIT_LSU;
                dec.imm      = imm_i;
                dec.rd_float = 1'b1;
                wb_en        = 1'b1;
                if (dec.funct3 != 3'b010)
                    dec.illegal = 1'b1;
            end
            OP_FSTORE: begin
                dec.unit      = UNIT_LSU;
                dec.imm       = imm_s;
                dec.rs2_float = 1'b1;
                if (dec.funct3 != 3'b010)
                    dec.illegal = 1'b1;
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                dec.unit      = UNIT_FPU;
                dec.rd_float  = 1'b1;
                dec.rs1_float = 1'b1;
                dec.rs2_float = 1'b1;
                wb_en         = 1'b1;
                uses_rm       = 1'b1;
                // funct2 selects the format; only single precision exists
                if (instr_i[26:25] != 2'b00)
                    dec.illegal = 1'b1;
            end
            OP_F_OPS: begin
                dec.unit      = UNIT_FPU;
                dec.rs2_float = 1'b1;
                wb_en         = 1'b1;
                uses_rm       = 1'b1;
                unique case (dec.funct7)
                    F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV, F7_FSQRT,
                    F7_FSGNJ, F7_FMINMAX: begin
                        dec.rd_float  = 1'b1;
                        dec.rs1_float = 1'b1;
                    end
                    // FP source, integer destination
                    F7_FCVTW, F7_FMV_CLS, F7_FCMP: begin
                        dec.rs1_float = 1'b1;
                    end
                    // integer source, FP destination
                    F7_FCVTS, F7_FMVWX: begin
                        dec.rd_float = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_FENCE: begin
                dec.unit = UNIT_FENCE;
                if (dec.funct3 > 3'b001)
                    dec.illegal = 1'b1;
            end
            OP_ECSR: begin
                dec.unit = UNIT_SYS;
                dec.imm  = imm_i;
                // funct3 = 000 is ECALL/EBREAK, which write nothing
                wb_en    = (dec.funct3 != 3'b000);
                if (dec.funct3 == 3'b100)
                    dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (uses_rm && (dec.funct3 == 3'b101 || dec.funct3 == 3'b110))
            dec.illegal = 1'b1;
        if (instr_i[1:0] != 2'b11)
            dec.illegal = 1'b1;

        // x0 as an integer destination is a discard; f0 is a real register
        dec.writeback = wb_en && !dec.illegal &&
                        (dec.rd_float || dec.rd != 5'd0);
    end

    // ------------------------------------------------------------------
    // Output register + skid buffer control
    // ------------------------------------------------------------------
    logic accept;
    logic deliver;

    assign fetch_ready_o = (state_q != ST_FULL);
    assign dec_valid_o   = (state_q != ST_EMPTY);
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign deliver       = dec_valid_o && dec_ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    out_d = dec;
                end else if (accept) begin
                    // Output is stalled: keep it stable, park the new word
                    state_d = ST_FULL;
                    skid_d  = dec;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides any same-cycle transfer; payload registers are
        // left as they were since nothing is valid afterwards.
        if (flush_i) begin
            state_d = ST_EMPTY;
            out_d   = out_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign pc_o        = out_q.pc;
    assign opcode_o    = out_q.opcode;
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign rd_o        = out_q.rd;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rs3_o       = out_q.rs3;
    assign imm_o       = out_q.imm;
    assign unit_o      = out_q.unit;
    assign rd_float_o  = out_q.rd_float;
    assign rs1_float_o = out_q.rs1_float;
    assign rs2_float_o = out_q.rs2_float;
    assign writeback_o = out_q.writeback;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. The driver issues instruction words with
// hand-computed expected immediate/unit/flag values and pushes the expected
// bundle when the word is accepted; an independent monitor pops and compares
// on every delivered bundle. Directed checks cover reset, backpressure,
// flush and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int W = 109;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, rs3_o;
  logic [31:0] imm_o;
  logic [2:0]  unit_o;
  logic        rd_float_o, rs1_float_o, rs2_float_o;
  logic        writeback_o, illegal_o;

  decode_stage dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .dec_valid_o  (dec_valid_o),
    .dec_ready_i  (dec_ready_i),
    .pc_o         (pc_o),
    .opcode_o     (opcode_o),
    .funct3_o     (funct3_o),
    .funct7_o     (funct7_o),
    .rd_o         (rd_o),
    .rs1_o        (rs1_o),
    .rs2_o        (rs2_o),
    .rs3_o        (rs3_o),
    .imm_o        (imm_o),
    .unit_o       (unit_o),
    .rd_float_o   (rd_float_o),
    .rs1_float_o  (rs1_float_o),
    .rs2_float_o  (rs2_float_o),
    .writeback_o  (writeback_o),
    .illegal_o    (illegal_o)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] mon_act;

  // Raw fields are plain slices of the word: {funct7,rs2,rs1,funct3,rd,opcode}
  function automatic logic [W-1:0] mk_exp(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [31:0] imm, input logic [2:0] unit,
                                          input logic rdf, input logic rs1f, input logic rs2f,
                                          input logic wb, input logic ill);
    return {pc, instr, instr[31:27], imm, unit, rdf, rs1f, rs2f, wb, ill};
  endfunction

  function automatic logic [W-1:0] dut_bundle();
    return {pc_o, funct7_o, rs2_o, rs1_o, funct3_o, rd_o, opcode_o, rs3_o, imm_o, unit_o,
            rd_float_o, rs1_float_o, rs2_float_o, writeback_o, illegal_o};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_i && dec_valid_o && dec_ready_i && !flush_i) begin
      mon_act = dut_bundle();
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_bundle: got %h expected no bundle", mon_act);
      end else begin
        check("bundle", mon_act, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [2:0] unit, input logic rdf, input logic rs1f,
                      input logic rs2f, input logic wb, input logic ill);
    int waited;
    waited = 0;
    instr_i = instr;
    pc_i = pc;
    fetch_valid_i = 1'b1;
    @(negedge clk);
    while (!fetch_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!fetch_ready_o) begin
      n_checks++;
      $display("FAIL send_timeout: fetch_ready_o=0 after 50 cycles, expected 1");
    end else begin
      exp_q.push_back(mk_exp(pc, instr, imm, unit, rdf, rs1f, rs2f, wb, ill));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fetch_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    #3;
    check("reset_valid", dec_valid_o, 1'b0);
    check("reset_ready", fetch_ready_o, 1'b1);
    #9 rst_i = 1'b0;
    check("reset_outputs", dut_bundle(), '0);
    @(posedge clk);
    #1;

    // Streaming with downstream always ready
    dec_ready_i = 1'b1;
    //     instr         pc            imm           unit rdf r1f r2f wb ill
    send(32'hFFF10093, 32'h0000_1000, 32'hFFFFFFFF, 3'd0, 0, 0, 0, 1, 0); // addi x1,x2,-1
    send(32'hFE000EE3, 32'h0000_1004, 32'hFFFFFFFC, 3'd1, 0, 0, 0, 0, 0); // beq x0,x0,-4
    send(32'h00532423, 32'h0000_1008, 32'h00000008, 3'd2, 0, 0, 0, 0, 0); // sw x5,8(x6)
    send(32'h022081B3, 32'h0000_100C, 32'h00000000, 3'd3, 0, 0, 0, 1, 0); // mul x3,x1,x2
    send(32'h00000000, 32'h0000_1010, 32'h00000000, 3'd0, 0, 0, 0, 0, 1); // all zero
    send(32'h123452B7, 32'h0000_1014, 32'h12345000, 3'd0, 0, 0, 0, 1, 0); // lui x5
    send(32'h008000EF, 32'h0000_1018, 32'h00000008, 3'd1, 0, 0, 0, 1, 0); // jal x1,8
    send(32'h0041A107, 32'h0000_101C, 32'h00000004, 3'd2, 1, 0, 0, 1, 0); // flw f2,4(x3)
    send(32'h00532427, 32'h0000_1020, 32'h00000008, 3'd2, 0, 0, 1, 0, 0); // fsw f5,8(x6)
    send(32'h003100D3, 32'h0000_1024, 32'h00000000, 3'd4, 1, 1, 1, 1, 0); // fadd.s
    send(32'hC00092D3, 32'h0000_1028, 32'h00000000, 3'd4, 0, 1, 1, 1, 0); // fcvt.w.s x5
    send(32'hD00100D3, 32'h0000_102C, 32'h00000000, 3'd4, 1, 0, 1, 1, 0); // fcvt.s.w f1
    send(32'h18208243, 32'h0000_1030, 32'h00000000, 3'd4, 1, 1, 1, 1, 0); // fmadd.s
    send(32'h1820D243, 32'h0000_1034, 32'h00000000, 3'd4, 1, 1, 1, 0, 1); // fmadd rm=101
    send(32'h300110F3, 32'h0000_1038, 32'h00000300, 3'd5, 0, 0, 0, 1, 0); // csrrw x1
    send(32'h00000073, 32'h0000_103C, 32'h00000000, 3'd5, 0, 0, 0, 0, 0); // ecall
    send(32'h0FF0000F, 32'h0000_1040, 32'h00000000, 3'd6, 0, 0, 0, 0, 0); // fence
    send(32'h00000013, 32'h0000_1044, 32'h00000000, 3'd0, 0, 0, 0, 0, 0); // nop (rd=x0)
    send(32'h403100B3, 32'h0000_1048, 32'h00000000, 3'd0, 0, 0, 0, 1, 0); // sub
    send(32'h403110B3, 32'h0000_104C, 32'h00000000, 3'd0, 0, 0, 0, 0, 1); // bad sll variant
    send(32'h00013083, 32'h0000_1050, 32'h00000000, 3'd2, 0, 0, 0, 0, 1); // ld (RV64 only)
    send(32'h40315093, 32'h0000_1054, 32'h00000403, 3'd0, 0, 0, 0, 1, 0); // srai x1,x2,3
    idle(3);

    // Backpressure: A and B fill the stage, C must stall at fetch
    dec_ready_i = 1'b0;
    send(32'hFFF10093, 32'h0000_2000, 32'hFFFFFFFF, 3'd0, 0, 0, 0, 1, 0);
    send(32'hFE000EE3, 32'h0000_2004, 32'hFFFFFFFC, 3'd1, 0, 0, 0, 0, 0);
    check("ready_low_when_full", fetch_ready_o, 1'b0);
    instr_i = 32'h00532423;
    pc_i = 32'h0000_2008;
    fetch_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("c_stalled", fetch_ready_o, 1'b0);
      check("held_pc", pc_o, 32'h0000_2000);
      check("held_imm", imm_o, 32'hFFFFFFFF);
    end
    @(posedge clk);
    #1;
    dec_ready_i = 1'b1;
    send(32'h00532423, 32'h0000_2008, 32'h00000008, 3'd2, 0, 0, 0, 0, 0);
    idle(4);

    // Flush while FULL with a word on offer: nothing may come out
    dec_ready_i = 1'b0;
    send(32'h123452B7, 32'h0000_3000, 32'h12345000, 3'd0, 0, 0, 0, 1, 0);
    send(32'h008000EF, 32'h0000_3004, 32'h00000008, 3'd1, 0, 0, 0, 1, 0);
    instr_i = 32'h003100D3;
    pc_i = 32'h0000_3008;
    fetch_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    exp_q.delete();
    check("flush_valid", dec_valid_o, 1'b0);
    check("flush_ready", fetch_ready_o, 1'b1);
    dec_ready_i = 1'b1;
    idle(5);

    // Asynchronous reset between edges while holding one bundle
    dec_ready_i = 1'b0;
    send(32'h300110F3, 32'h0000_4000, 32'h00000300, 3'd5, 0, 0, 0, 1, 0);
    fetch_valid_i = 1'b0;
    check("one_valid", dec_valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    exp_q.delete();
    check("areset_valid", dec_valid_o, 1'b0);
    check("areset_ready", fetch_ready_o, 1'b1);
    check("areset_outputs", dut_bundle(), '0);
    @(posedge clk);
    #3 rst_i = 1'b0;
    @(posedge clk);
    #1;
    dec_ready_i = 1'b1;
    check("post_reset_valid", dec_valid_o, 1'b0);
    idle(3);

    // Stream resumes normally after reset
    send(32'h022081B3, 32'h0000_5000, 32'h00000000, 3'd3, 0, 0, 0, 1, 0);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
